uart_link: RTL

//  Parametrised board-to-board serial link for the GPIO inter-board channel. Full-duplex UART
//  (start/data/optional parity/stop) with TX and RX FIFOs and valid/ready streams, replacing the

---
 rtl/uart_link.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_link.sv
// uart_link: full-duplex UART with TX/RX FIFOs and valid/ready byte streams.
// Frame: start(0), DATA_BITS LSB first, optional even/odd parity, one stop(1).
module uart_link #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int TX_DEPTH     = 8,
    parameter int RX_DEPTH     = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 rxd,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // Both streams: a beat transfers on the rising edge where valid & ready are both 1;
    // valid may not depend on ready, and ready only reflects FIFO space/occupancy.

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]         tx_wptr, tx_rptr;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TAW] != tx_rptr[TAW]) && (tx_wptr[TAW-1:0] == tx_rptr[TAW-1:0]);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;
    assign tx_head  = tx_mem[tx_rptr[TAW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + (TAW+1)'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + (TAW+1)'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (tx_push) tx_mem[tx_wptr[TAW-1:0]] <= tx_data;
    end

    // ---------------- TX FSM ----------------
    state_t               tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_tick, tx_line;

    assign tx_tick = (tx_cnt == CNT_LAST);
    assign tx_busy = (tx_state != S_IDLE) || !tx_empty;

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx_line = 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_next = S_START;
                    tx_pop  = 1'b1;
                end
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_next = S_DATA;
            end
            S_DATA: begin
                tx_line = tx_shift[0];
                if (tx_tick && tx_bit == BIT_LAST) tx_next = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                tx_line = tx_par;
                if (tx_tick) tx_next = S_STOP;
            end
            S_STOP: begin
                // Chain straight into the next start bit so queued bytes leave gap-free.
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_next = S_START;
                        tx_pop  = 1'b1;
                    end else begin
                        tx_next = S_IDLE;
                    end
                end
            end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else begin
            txd <= tx_line;
            if (tx_pop) begin
                tx_cnt   <= '0;
                tx_bit   <= '0;
                tx_shift <= tx_head;
                tx_par   <= (PARITY == 2) ? ~^tx_head : ^tx_head;
            end else if (tx_state != S_IDLE) begin
                tx_cnt <= tx_tick ? '0 : tx_cnt + CW'(1);
                if (tx_tick && tx_state == S_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + BW'(1);
                end
            end
        end
    end

    // ---------------- RX FSM ----------------
    state_t               rx_state, rx_next;
    logic                 rx_s1, rx_s2, rx_prev;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit, rx_tick, rx_half, rx_stop_chk;
    logic                 rx_par_exp, rx_par_bad, rx_push_req, rx_push, rx_pop;
    logic                 rx_full, rx_empty;

    assign rx_tick     = (rx_cnt == CNT_LAST);
    assign rx_half     = (rx_cnt == CNT_HALF);
    assign rx_par_exp  = (PARITY == 2) ? ~^rx_shift : ^rx_shift;
    assign rx_par_bad  = (PARITY != 0) && (rx_par_bit != rx_par_exp);
    assign rx_push_req = rx_stop_chk && rx_s2 && !rx_par_bad;
    assign rx_pop      = rx_valid && rx_ready;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);

    always_comb begin
        rx_next     = rx_state;
        rx_stop_chk = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s2) rx_next = S_START;
            S_START: if (rx_half) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == BIT_LAST) rx_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (rx_tick) rx_next = S_STOP;
            S_STOP: begin
                if (rx_tick) begin
                    rx_next     = S_IDLE;
                    rx_stop_chk = 1'b1;
                end
            end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) rx_state <= S_IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_bit <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_s1      <= rxd;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            frame_err  <= rx_stop_chk && !rx_s2;
            parity_err <= rx_stop_chk && rx_s2 && rx_par_bad;
            overrun    <= rx_push_req && rx_full && !rx_pop;
            // The half-bit sample re-phases the counter so later samples land mid-bit.
            if (rx_state == S_IDLE || (rx_state == S_START && rx_half)) begin
                rx_cnt <= '0;
                rx_bit <= '0;
            end else begin
                rx_cnt <= rx_tick ? '0 : rx_cnt + CW'(1);
                if (rx_tick && rx_state == S_DATA) begin
                    rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                    rx_bit   <= rx_bit + BW'(1);
                end
                if (rx_tick && rx_state == S_PAR) rx_par_bit <= rx_s2;
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RAW:0]         rx_wptr, rx_rptr;

    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[RAW] != rx_rptr[RAW]) && (rx_wptr[RAW-1:0] == rx_rptr[RAW-1:0]);
    assign rx_valid = !rx_empty;
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rptr[RAW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + (RAW+1)'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + (RAW+1)'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rx_push) rx_mem[rx_wptr[RAW-1:0]] <= rx_shift;
    end

endmodule
